// File: rtl/rob_pkg.sv
// Shared definitions for the multi-commit reorder buffer.
//   - instruction type encodings (BR/ST/JALR/RG)
//   - entry status encodings (IS = issued, WR = written back)
//   - default geometry and the per-entry payload struct
package rob_pkg;

    localparam int ROB_DEPTH_DEF = 16;
    localparam int ROB_W_DEF     = 4;

    typedef enum logic [1:0] {
        TY_BR   = 2'b00,
        TY_ST   = 2'b01,
        TY_JALR = 2'b10,
        TY_RG   = 2'b11
    } rob_type_e;

    typedef enum logic {
        ST_IS = 1'b0,
        ST_WR = 1'b1
    } rob_status_e;

    // Payload that needs no reset; busy/status live in reset flops.
    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] j_addr;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_search_port.sv
// One registered operand-search lane with the writeback bypass mux.
//   clk/rst/rdy              : clock, async active-high reset, pause
//   has_dep/rob_id/val       : regfile lookup request
//   entry_wr/entry_val       : status/value of the looked-up ROB entry
//   wb_valid/wb_rob_id/wb_value : same-cycle writeback channels (packed)
//   dep_flag/dep/val_o       : registered answer
module rob_search_port
    import rob_pkg::*;
#(
    parameter int ROB_W  = ROB_W_DEF,
    parameter int NUM_WB = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    has_dep,
    input  logic [ROB_W-1:0]        rob_id,
    input  logic [31:0]             val,
    input  logic                    entry_wr,
    input  logic [31:0]             entry_val,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*ROB_W-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]    wb_value,
    output logic                    dep_flag,
    output logic [ROB_W-1:0]        dep,
    output logic [31:0]             val_o
);

    logic        hit;
    logic [31:0] byp_val;

    // Later channels override earlier ones; any channel overrides storage.
    always_comb begin
        hit     = 1'b0;
        byp_val = entry_val;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_rob_id[k*ROB_W +: ROB_W] == rob_id) begin
                hit     = 1'b1;
                byp_val = wb_value[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dep_flag <= 1'b0;
            dep      <= '0;
            val_o    <= '0;
        end else if (rdy) begin
            if (!has_dep) begin
                dep_flag <= 1'b0;
                dep      <= '0;
                val_o    <= val;
            end else if (entry_wr || hit) begin
                dep_flag <= 1'b0;
                dep      <= '0;
                val_o    <= byp_val;
            end else begin
                dep_flag <= 1'b1;
                dep      <= rob_id;
                val_o    <= '0;
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Parametrised reorder buffer with NUM_WB writeback channels and up to
// COMMIT_W (1 or 2) in-order commits per cycle. An occupancy counter
// distinguishes full from empty so all ROB_DEPTH entries are usable.
//   clk_in/rst_in/rdy_in     : clock, async active-high reset, pause
//   rob_full/rob_empty       : occupancy flags; empty_rob_id = tail
//   dec_ready/dec_type/rd/j_addr : issue port
//   wb_valid/wb_rob_id/wb_value  : packed writeback channels
//   store_enable             : head is a busy store
//   commit_*                 : registered per-slot commit outputs
//   melt/clear/corr_jump_addr: JALR pulse, mispredict flush, redirect
//   search_*_1/2             : two registered operand-search ports
module rob_multi
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int ROB_W     = ROB_W_DEF,
    parameter int NUM_WB    = 2,
    parameter int COMMIT_W  = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    output logic                      rob_full,
    output logic                      rob_empty,
    output logic [ROB_W-1:0]          empty_rob_id,
    input  logic                      dec_ready,
    input  logic [1:0]                dec_type,
    input  logic [4:0]                rd,
    input  logic [31:0]               j_addr,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ROB_W-1:0]   wb_rob_id,
    input  logic [NUM_WB*32-1:0]      wb_value,
    output logic                      store_enable,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W*ROB_W-1:0] commit_rob_id,
    output logic [COMMIT_W*5-1:0]     commit_reg_id,
    output logic [COMMIT_W*32-1:0]    commit_val,
    output logic                      melt,
    output logic                      clear,
    output logic [31:0]               corr_jump_addr,
    input  logic                      search_has_dep_1,
    input  logic [ROB_W-1:0]          search_rob_id_1,
    input  logic [31:0]               search_val_1,
    output logic                      search_dep_flag_1,
    output logic [ROB_W-1:0]          search_dep_1,
    output logic [31:0]               search_val_o_1,
    input  logic                      search_has_dep_2,
    input  logic [ROB_W-1:0]          search_rob_id_2,
    input  logic [31:0]               search_val_2,
    output logic                      search_dep_flag_2,
    output logic [ROB_W-1:0]          search_dep_2,
    output logic [31:0]               search_val_o_2
);

    rob_entry_t             ent [ROB_DEPTH];
    logic [ROB_DEPTH-1:0]   busy;
    logic [ROB_DEPTH-1:0]   stat;
    logic [ROB_W-1:0]       head, tail;
    logic [ROB_W:0]         count;

    logic                   do_issue;
    logic [1:0]             fire;
    logic [1:0][ROB_W-1:0]  sid;
    logic [ROB_W:0]         n_commit;
    logic [NUM_WB-1:0]      wb_hit;
    logic [ROB_W-1:0]       wid  [NUM_WB];
    logic [31:0]            wval [NUM_WB];

    assign rob_full     = (count == (ROB_W+1)'(ROB_DEPTH));
    assign rob_empty    = (count == '0);
    assign empty_rob_id = tail;
    assign store_enable = busy[head] && ent[head].typ == TY_ST;

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            wid[k]    = wb_rob_id[k*ROB_W +: ROB_W];
            wval[k]   = wb_value[k*32 +: 32];
            wb_hit[k] = wb_valid[k] && busy[wid[k]];
        end
    end

    // Slot 1 only pairs two register-writing entries, so redirects
    // (BR/JALR) and stores always commit alone.
    always_comb begin
        do_issue = dec_ready && !rob_full;
        sid[0]   = head;
        sid[1]   = head + 1'b1;
        fire     = 2'b00;
        fire[0]  = busy[sid[0]] && stat[sid[0]] == ST_WR;
        if (COMMIT_W == 2)
            fire[1] = fire[0] && ent[sid[0]].typ == TY_RG &&
                      busy[sid[1]] && stat[sid[1]] == ST_WR &&
                      ent[sid[1]].typ == TY_RG;
        n_commit = {{ROB_W{1'b0}}, fire[0]} + {{ROB_W{1'b0}}, fire[1]};
    end

    // Entry payload: no reset needed, busy/status gate its use.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !clear) begin
            for (int k = 0; k < NUM_WB; k++)
                if (wb_hit[k]) ent[wid[k]].value <= wval[k];
            if (do_issue)
                ent[tail] <= '{typ: rob_type_e'(dec_type), rd: rd,
                               j_addr: j_addr, value: 32'd0};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            stat           <= '0;
            commit_valid   <= '0;
            commit_rob_id  <= '0;
            commit_reg_id  <= '0;
            commit_val     <= '0;
            melt           <= 1'b0;
            clear          <= 1'b0;
            corr_jump_addr <= '0;
        end else if (rdy_in) begin
            commit_valid  <= '0;
            commit_rob_id <= '0;
            commit_reg_id <= '0;
            commit_val    <= '0;
            melt          <= 1'b0;
            clear         <= 1'b0;
            if (clear) begin
                // Flush: everything still in flight is younger than the
                // mispredicted branch, so drop it all.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                stat  <= '0;
            end else begin
                for (int k = 0; k < NUM_WB; k++)
                    if (wb_hit[k]) stat[wid[k]] <= ST_WR;
                for (int s = 0; s < COMMIT_W; s++) begin
                    if (fire[s]) begin
                        busy[sid[s]] <= 1'b0;
                        commit_valid[s] <= ent[sid[s]].typ == TY_RG ||
                                           ent[sid[s]].typ == TY_JALR;
                        commit_rob_id[s*ROB_W +: ROB_W] <= sid[s];
                        commit_reg_id[s*5 +: 5]         <= ent[sid[s]].rd;
                        commit_val[s*32 +: 32] <= (ent[sid[s]].typ == TY_JALR) ?
                                                  ent[sid[s]].j_addr : ent[sid[s]].value;
                        if (ent[sid[s]].typ == TY_JALR) begin
                            melt           <= 1'b1;
                            corr_jump_addr <= ent[sid[s]].value;
                        end
                        if (ent[sid[s]].typ == TY_BR &&
                            ent[sid[s]].value != ent[sid[s]].j_addr) begin
                            clear          <= 1'b1;
                            corr_jump_addr <= ent[sid[s]].value;
                        end
                    end
                end
                // Issue after commit so a freed slot is never re-cleared.
                if (do_issue) begin
                    busy[tail] <= 1'b1;
                    stat[tail] <= ST_IS;
                    tail       <= tail + 1'b1;
                end
                head  <= head + n_commit[ROB_W-1:0];
                count <= count + {{ROB_W{1'b0}}, do_issue} - n_commit;
            end
        end
    end

    rob_search_port #(.ROB_W(ROB_W), .NUM_WB(NUM_WB)) u_search_1 (
        .clk       (clk_in),
        .rst       (rst_in),
        .rdy       (rdy_in),
        .has_dep   (search_has_dep_1),
        .rob_id    (search_rob_id_1),
        .val       (search_val_1),
        .entry_wr  (stat[search_rob_id_1] == ST_WR),
        .entry_val (ent[search_rob_id_1].value),
        .wb_valid  (wb_valid),
        .wb_rob_id (wb_rob_id),
        .wb_value  (wb_value),
        .dep_flag  (search_dep_flag_1),
        .dep       (search_dep_1),
        .val_o     (search_val_o_1)
    );

    rob_search_port #(.ROB_W(ROB_W), .NUM_WB(NUM_WB)) u_search_2 (
        .clk       (clk_in),
        .rst       (rst_in),
        .rdy       (rdy_in),
        .has_dep   (search_has_dep_2),
        .rob_id    (search_rob_id_2),
        .val       (search_val_2),
        .entry_wr  (stat[search_rob_id_2] == ST_WR),
        .entry_val (ent[search_rob_id_2].value),
        .wb_valid  (wb_valid),
        .wb_rob_id (wb_rob_id),
        .wb_value  (wb_value),
        .dep_flag  (search_dep_flag_2),
        .dep       (search_dep_2),
        .val_o     (search_val_o_2)
    );

endmodule

// File: tb/tb_rob_multi.sv
// Directed self-checking bench for rob_multi (default geometry:
// 16 entries, 2 writeback channels, 2 commit slots).
module tb_rob_multi;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        rob_full, rob_empty;
    logic [3:0]  empty_rob_id;
    logic        dec_ready;
    logic [1:0]  dec_type;
    logic [4:0]  rd;
    logic [31:0] j_addr;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_value;
    logic        store_enable;
    logic [1:0]  commit_valid;
    logic [7:0]  commit_rob_id;
    logic [9:0]  commit_reg_id;
    logic [63:0] commit_val;
    logic        melt, clear;
    logic [31:0] corr_jump_addr;
    logic        search_has_dep_1, search_has_dep_2;
    logic [3:0]  search_rob_id_1, search_rob_id_2;
    logic [31:0] search_val_1, search_val_2;
    logic        search_dep_flag_1, search_dep_flag_2;
    logic [3:0]  search_dep_1, search_dep_2;
    logic [31:0] search_val_o_1, search_val_o_2;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] BR = 2'b00, ST = 2'b01, JALR = 2'b10, RG = 2'b11;

    rob_multi dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .rob_empty(rob_empty), .empty_rob_id(empty_rob_id),
        .dec_ready(dec_ready), .dec_type(dec_type), .rd(rd), .j_addr(j_addr),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .store_enable(store_enable), .commit_valid(commit_valid),
        .commit_rob_id(commit_rob_id), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val), .melt(melt), .clear(clear),
        .corr_jump_addr(corr_jump_addr),
        .search_has_dep_1(search_has_dep_1), .search_rob_id_1(search_rob_id_1),
        .search_val_1(search_val_1), .search_dep_flag_1(search_dep_flag_1),
        .search_dep_1(search_dep_1), .search_val_o_1(search_val_o_1),
        .search_has_dep_2(search_has_dep_2), .search_rob_id_2(search_rob_id_2),
        .search_val_2(search_val_2), .search_dep_flag_2(search_dep_flag_2),
        .search_dep_2(search_dep_2), .search_val_o_2(search_val_o_2)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] ty, input logic [4:0] r, input logic [31:0] ja);
        dec_ready = 1'b1; dec_type = ty; rd = r; j_addr = ja;
        tick();
        dec_ready = 1'b0;
    endtask

    task automatic wb(input logic [1:0] v, input logic [3:0] i0, input logic [31:0] v0,
                      input logic [3:0] i1, input logic [31:0] v1);
        wb_valid = v; wb_rob_id = {i1, i0}; wb_value = {v1, v0};
        tick();
        wb_valid = 2'b00;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        dec_ready = 1'b0; dec_type = RG; rd = '0; j_addr = '0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0;
        search_has_dep_1 = 1'b0; search_rob_id_1 = '0; search_val_1 = '0;
        search_has_dep_2 = 1'b0; search_rob_id_2 = '0; search_val_2 = '0;

        // reset state, before any clock edge
        #3;
        chk("rst_empty", rob_empty, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_tail", empty_rob_id, 0);
        chk("rst_cvalid", commit_valid, 0);
        chk("rst_clear_melt", {clear, melt}, 0);
        tick(); tick();
        rst_in = 1'b0;

        // fill: 16 issues, no writebacks
        for (int i = 0; i < 16; i++) begin
            issue(RG, 5'(i + 1), 32'd0);
            if (i == 14) begin
                chk("fill15_full", rob_full, 0);
                chk("fill15_tail", empty_rob_id, 15);
            end
        end
        chk("fill16_full", rob_full, 1);
        chk("fill16_tail", empty_rob_id, 0);
        issue(ST, 5'd9, 32'd0);
        chk("fill17_full", rob_full, 1);
        chk("fill17_tail", empty_rob_id, 0);
        chk("fill17_store_en", store_enable, 0);

        // dual commit of ids 0,1 written on both channels together
        wb(2'b11, 4'd0, 32'h11, 4'd1, 32'h22);
        chk("dual_wait", commit_valid, 0);
        tick();
        chk("dual_valid", commit_valid, 2'b11);
        chk("dual_val", commit_val, 64'h00000022_00000011);
        chk("dual_reg", commit_reg_id, {5'd2, 5'd1});
        chk("dual_id", commit_rob_id, 8'h10);
        chk("dual_full", rob_full, 0);
        chk("dual_head", dut.head, 2);

        // asynchronous reset mid-stream, no clock edge
        #2 rst_in = 1'b1;
        #1;
        chk("arst_cvalid", commit_valid, 0);
        chk("arst_empty", rob_empty, 1);
        chk("arst_head", dut.head, 0);
        tick();
        rst_in = 1'b0;

        // mispredict: BR then three younger entries
        issue(BR, 5'd0, 32'h100);
        issue(RG, 5'd3, 32'd0);
        issue(RG, 5'd4, 32'd0);
        issue(RG, 5'd5, 32'd0);
        wb(2'b01, 4'd0, 32'h200, 4'd0, 32'd0);
        tick();
        chk("misp_clear", clear, 1);
        chk("misp_corr", corr_jump_addr, 32'h200);
        chk("misp_cvalid", commit_valid, 0);
        chk("misp_notempty", rob_empty, 0);
        tick();
        chk("flush_clear", clear, 0);
        chk("flush_empty", rob_empty, 1);
        chk("flush_tail", empty_rob_id, 0);

        // JALR followed by RG: RG must not pair with the JALR
        issue(JALR, 5'd1, 32'h44);
        issue(RG, 5'd7, 32'd0);
        wb(2'b11, 4'd0, 32'h80, 4'd1, 32'h55);
        tick();
        chk("jalr_valid", commit_valid, 2'b01);
        chk("jalr_val", commit_val[31:0], 32'h44);
        chk("jalr_reg", commit_reg_id[4:0], 1);
        chk("jalr_corr", corr_jump_addr, 32'h80);
        chk("jalr_melt", melt, 1);
        chk("jalr_noclear", clear, 0);
        tick();
        chk("jalr_melt_drop", melt, 0);
        chk("after_jalr_valid", commit_valid, 2'b01);
        chk("after_jalr_val", commit_val[31:0], 32'h55);
        chk("after_jalr_reg", commit_reg_id[4:0], 7);
        tick();
        chk("idle_valid", commit_valid, 0);

        // search: bypass, pass-through, pending dep, channel priority
        search_has_dep_1 = 1'b1; search_rob_id_1 = 4'd5;
        search_has_dep_2 = 1'b0; search_val_2 = 32'h1234;
        wb(2'b10, 4'd0, 32'd0, 4'd5, 32'hABCD);
        chk("srch1_byp_flag", search_dep_flag_1, 0);
        chk("srch1_byp_val", search_val_o_1, 32'hABCD);
        chk("srch2_pass_flag", search_dep_flag_2, 0);
        chk("srch2_pass_val", search_val_o_2, 32'h1234);
        search_rob_id_1 = 4'd6;
        search_has_dep_2 = 1'b1; search_rob_id_2 = 4'd9;
        wb(2'b11, 4'd9, 32'h1, 4'd9, 32'h2);
        chk("srch1_dep_flag", search_dep_flag_1, 1);
        chk("srch1_dep_id", search_dep_1, 6);
        chk("srch1_dep_val", search_val_o_1, 0);
        chk("srch2_prio_val", search_val_o_2, 32'h2);
        search_has_dep_1 = 1'b0; search_has_dep_2 = 1'b0;

        // drain to head=tail=15: issue ids 2..14, write back in pairs
        for (int i = 0; i < 13; i++) issue(RG, 5'd1, 32'd0);
        for (int p = 0; p < 7; p++)
            wb(2'b11, 4'(2 + 2 * p), 32'(p), 4'(3 + 2 * p), 32'(p));
        tick(); tick(); tick();
        chk("wrap_pre_tail", empty_rob_id, 15);
        chk("wrap_pre_head", dut.head, 15);
        chk("wrap_pre_empty", rob_empty, 1);

        // dual commit straddling the wrap: ids 15 and 0
        issue(RG, 5'd3, 32'd0);
        chk("wrap_tail0", empty_rob_id, 0);
        issue(RG, 5'd4, 32'd0);
        chk("wrap_tail1", empty_rob_id, 1);
        wb(2'b11, 4'd15, 32'h15, 4'd0, 32'h20);
        search_has_dep_1 = 1'b1; search_rob_id_1 = 4'd15;
        tick();
        search_has_dep_1 = 1'b0;
        chk("wrap_valid", commit_valid, 2'b11);
        chk("wrap_id", commit_rob_id, 8'h0F);
        chk("wrap_val", commit_val, 64'h00000020_00000015);
        chk("wrap_head", dut.head, 1);
        chk("srch_stored_flag", search_dep_flag_1, 0);
        chk("srch_stored_val", search_val_o_1, 32'h15);

        // store at head
        issue(ST, 5'd0, 32'd0);
        chk("st_enable", store_enable, 1);
        wb(2'b01, 4'd1, 32'h99, 4'd0, 32'd0);
        tick();
        chk("st_cvalid", commit_valid, 0);
        chk("st_enable_off", store_enable, 0);

        // pause: issue is ignored while rdy_in is low
        rdy_in = 1'b0;
        issue(RG, 5'd2, 32'd0);
        chk("pause_tail", empty_rob_id, 2);
        chk("pause_empty", rob_empty, 1);
        rdy_in = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
